// File: rtl/gpu_pipe_ctrl_n.sv
// Texel/CLUT pixel pipeline controller: S0 issue, S1 texture lookup/CLUT index,
// S2 texel select, then a valid/ready output FIFO. Texture misses are resolved
// locally by a fill/replay FSM that holds the missing pixel in S1.
module gpu_pipe_ctrl_n #(
    parameter int unsigned PAYLOAD_W  = 48,
    parameter int unsigned TEXADR_W   = 19,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  i_nrst,
    input  logic [1:0]            i_texFormat,
    input  logic                  i_texDisable,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [PAYLOAD_W-1:0]  i_payload,
    input  logic [TEXADR_W-1:0]   i_texAdr,
    input  logic [1:0]            i_uLSB,
    output logic                  o_texReq,
    output logic [TEXADR_W-1:0]   o_texAdr,
    input  logic                  i_texHit,
    input  logic                  i_texMiss,
    input  logic [15:0]           i_texData,
    output logic                  o_fillReq,
    output logic [TEXADR_W-3:0]   o_fillAdr,
    input  logic                  i_fillDone,
    output logic [7:0]            o_clutIndex,
    input  logic [15:0]           i_clutData,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [PAYLOAD_W-1:0]  o_payload,
    output logic [15:0]           o_texel,
    output logic                  o_transparent,
    output logic                  o_inFlight,
    output logic [CNT_W-1:0]      o_missCnt
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_FW = PTR_W + 1;

    typedef enum logic [1:0] {ST_RUN, ST_FILL, ST_REPLAY, ST_CHECK} state_e;

    state_e                 state_q, state_d;
    logic                   rdy_en_q;
    logic                   s1_valid_q, s1_valid_d, s1_tex_q, s1_tex_d;
    logic [PAYLOAD_W-1:0]   s1_pay_q, s1_pay_d;
    logic [1:0]             s1_ulsb_q, s1_ulsb_d;
    logic [TEXADR_W-1:0]    s1_adr_q, s1_adr_d;
    logic                   s2_valid_q, s2_valid_d, s2_tex_q, s2_tex_d;
    logic [PAYLOAD_W-1:0]   s2_pay_q, s2_pay_d;
    logic [15:0]            s2_data_q, s2_data_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_FW-1:0]      fcnt_q, fcnt_d;
    logic [CNT_W-1:0]       miss_cnt_q, miss_cnt_d;

    logic [PAYLOAD_W-1:0]   fifo_pay [FIFO_DEPTH];
    logic [15:0]            fifo_tex [FIFO_DEPTH];
    logic                   fifo_tr  [FIFO_DEPTH];

    logic                   miss_run, miss_chk, hit_chk, accept, advance, inc_miss;
    logic                   push, pop;
    logic [CNT_FW-1:0]      free_w, busy_w;
    logic [15:0]            s2_texel;
    logic                   s2_transp;

    // Handshake, credit and miss/hit qualification.
    always_comb begin
        miss_run = (state_q == ST_RUN) & s1_valid_q & s1_tex_q & i_texMiss & ~i_flush;
        miss_chk = (state_q == ST_CHECK) & i_texMiss & ~i_flush;
        hit_chk  = (state_q == ST_CHECK) & i_texHit & ~i_texMiss & ~i_flush;
        free_w   = CNT_FW'(FIFO_DEPTH) - fcnt_q;
        busy_w   = CNT_FW'(s1_valid_q) + CNT_FW'(s2_valid_q);
        // A miss seen this cycle freezes S1, so nothing may be accepted behind it.
        o_ready  = rdy_en_q & (state_q == ST_RUN) & ~i_flush & ~miss_run & (free_w > busy_w);
        accept   = i_valid & o_ready;
        advance  = s1_valid_q & (((state_q == ST_RUN) & ~miss_run) | hit_chk);
        o_texReq = ((state_q == ST_REPLAY) & ~i_flush) | (accept & ~i_texDisable);
        o_texAdr = (state_q == ST_REPLAY) ? s1_adr_q : i_texAdr;
        o_fillReq = (state_q == ST_FILL);
        o_fillAdr = s1_adr_q[TEXADR_W-1:2];
    end

    // Miss FSM next state; a flushed held pixel skips the replay.
    always_comb begin
        state_d  = state_q;
        inc_miss = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (miss_run) begin
                    state_d  = ST_FILL;
                    inc_miss = 1'b1;
                end
            end
            ST_FILL: begin
                if (i_fillDone) state_d = (s1_valid_q & ~i_flush) ? ST_REPLAY : ST_RUN;
            end
            ST_REPLAY: state_d = i_flush ? ST_RUN : ST_CHECK;
            ST_CHECK: begin
                if (i_flush) state_d = ST_RUN;
                else if (miss_chk) begin
                    state_d  = ST_FILL;
                    inc_miss = 1'b1;
                end else if (hit_chk) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        miss_cnt_d = (inc_miss && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
    end

    // CLUT index from the lookup data returning while the pixel sits in S1.
    always_comb begin
        o_clutIndex = '0;
        unique case (i_texFormat)
            2'd0:    o_clutIndex = {4'h0, 4'(i_texData >> {s1_ulsb_q, 2'b00})};
            2'd1:    o_clutIndex = s1_ulsb_q[0] ? i_texData[15:8] : i_texData[7:0];
            default: o_clutIndex = '0;
        endcase
    end

    // S1/S2 stage next state.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tex_d   = s1_tex_q;
        s1_pay_d   = s1_pay_q;
        s1_ulsb_d  = s1_ulsb_q;
        s1_adr_d   = s1_adr_q;
        s2_valid_d = advance;
        s2_tex_d   = s2_tex_q;
        s2_pay_d   = s2_pay_q;
        s2_data_d  = s2_data_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_tex_d   = ~i_texDisable;
            s1_pay_d   = i_payload;
            s1_ulsb_d  = i_uLSB;
            s1_adr_d   = i_texAdr;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
        if (advance) begin
            s2_tex_d  = s1_tex_q;
            s2_pay_d  = s1_pay_q;
            s2_data_d = i_texData;
        end
        if (i_flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // S2 texel select and output FIFO bookkeeping.
    always_comb begin
        s2_texel  = ~s2_tex_q ? 16'h7FFF : (i_texFormat[1] ? s2_data_q : i_clutData);
        s2_transp = s2_tex_q & (s2_texel[14:0] == 15'd0);
        o_valid   = (fcnt_q != '0);
        push      = s2_valid_q & ~i_flush;
        pop       = o_valid & i_ready & ~i_flush;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fcnt_d    = fcnt_q + CNT_FW'(push) - CNT_FW'(pop);
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fcnt_d   = '0;
        end
        o_payload     = fifo_pay[rd_ptr_q];
        o_texel       = fifo_tex[rd_ptr_q];
        o_transparent = o_valid & fifo_tr[rd_ptr_q];
        o_inFlight    = s1_valid_q | s2_valid_q | o_valid;
        o_missCnt     = miss_cnt_q;
    end

    // Control and stage registers.
    always_ff @(posedge clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_RUN;
            rdy_en_q   <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_tex_q   <= 1'b0;
            s1_pay_q   <= '0;
            s1_ulsb_q  <= '0;
            s1_adr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_tex_q   <= 1'b0;
            s2_pay_q   <= '0;
            s2_data_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fcnt_q     <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s1_tex_q   <= s1_tex_d;
            s1_pay_q   <= s1_pay_d;
            s1_ulsb_q  <= s1_ulsb_d;
            s1_adr_q   <= s1_adr_d;
            s2_valid_q <= s2_valid_d;
            s2_tex_q   <= s2_tex_d;
            s2_pay_q   <= s2_pay_d;
            s2_data_q  <= s2_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fcnt_q     <= fcnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // FIFO storage; occupancy is tracked by the reset counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pay[wr_ptr_q] <= s2_pay_q;
            fifo_tex[wr_ptr_q] <= s2_texel;
            fifo_tr[wr_ptr_q]  <= s2_transp;
        end
    end

endmodule

// File: tb/tb_gpu_pipe_ctrl_n.sv
// Directed bench for gpu_pipe_ctrl_n with a behavioural texture cache and CLUT.
module tb_gpu_pipe_ctrl_n;

    logic        clk;
    logic        i_nrst;
    logic [1:0]  i_texFormat;
    logic        i_texDisable, i_flush, i_valid, o_ready;
    logic [47:0] i_payload;
    logic [18:0] i_texAdr;
    logic [1:0]  i_uLSB;
    logic        o_texReq;
    logic [18:0] o_texAdr;
    logic        i_texHit, i_texMiss;
    logic [15:0] i_texData;
    logic        o_fillReq;
    logic [16:0] o_fillAdr;
    logic        i_fillDone;
    logic [7:0]  o_clutIndex;
    logic [15:0] i_clutData;
    logic        o_valid, i_ready;
    logic [47:0] o_payload;
    logic [15:0] o_texel;
    logic        o_transparent, o_inFlight;
    logic [15:0] o_missCnt;

    gpu_pipe_ctrl_n #(
        .PAYLOAD_W(48), .TEXADR_W(19), .FIFO_DEPTH(4), .CNT_W(16)
    ) dut (
        .clk(clk), .i_nrst(i_nrst), .i_texFormat(i_texFormat), .i_texDisable(i_texDisable),
        .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready), .i_payload(i_payload),
        .i_texAdr(i_texAdr), .i_uLSB(i_uLSB), .o_texReq(o_texReq), .o_texAdr(o_texAdr),
        .i_texHit(i_texHit), .i_texMiss(i_texMiss), .i_texData(i_texData),
        .o_fillReq(o_fillReq), .o_fillAdr(o_fillAdr), .i_fillDone(i_fillDone),
        .o_clutIndex(o_clutIndex), .i_clutData(i_clutData), .o_valid(o_valid),
        .i_ready(i_ready), .o_payload(o_payload), .o_texel(o_texel),
        .o_transparent(o_transparent), .o_inFlight(o_inFlight), .o_missCnt(o_missCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t_acc0, t_val0;
    logic last_acc, acc_prev;
    logic [7:0]  idx_s1;
    logic [47:0] got_pay [$];
    logic [15:0] got_tex [$];
    logic        got_tr  [$];
    logic        miss_armed;
    logic [18:0] miss_adr;
    logic [15:0] tex_base;
    logic [15:0] clut_tab [256];
    int          fill_delay, fill_cyc, fill_hi;
    logic [16:0] fill_adr_seen;

    // One clock: sample outputs before the edge, answer cache/CLUT/fill after it.
    task automatic tick();
        logic req, acc, pop;
        logic [18:0] adr;
        logic [7:0]  idx;
        #1;
        req = o_texReq;
        adr = o_texAdr;
        idx = o_clutIndex;
        acc = i_valid & o_ready;
        pop = o_valid & i_ready;
        if (pop) begin
            got_pay.push_back(o_payload);
            got_tex.push_back(o_texel);
            got_tr.push_back(o_transparent);
        end
        if (acc_prev) idx_s1 = idx;
        if (acc && t_acc0 < 0) t_acc0 = cyc;
        if (o_valid && t_val0 < 0) t_val0 = cyc;
        if (o_fillReq) begin
            fill_cyc++;
            fill_hi++;
            fill_adr_seen = o_fillAdr;
        end
        last_acc = acc;
        acc_prev = acc;
        @(posedge clk);
        #1;
        cyc++;
        i_clutData = clut_tab[idx];
        i_texHit   = 1'b0;
        i_texMiss  = 1'b0;
        i_texData  = '0;
        if (req) begin
            if (miss_armed && adr == miss_adr) begin
                i_texMiss  = 1'b1;
                miss_armed = 1'b0;
            end else begin
                i_texHit  = 1'b1;
                i_texData = tex_base + adr[15:0];
            end
        end
        i_fillDone = (fill_cyc == fill_delay);
    endtask

    task automatic feed(input int n, input logic [47:0] pb, input logic [18:0] ab,
                        input int budget, output int sent);
        int c = 0;
        sent = 0;
        while (sent < n && c < budget) begin
            i_valid   = 1'b1;
            i_payload = pb + 48'(sent);
            i_texAdr  = ab + 19'(sent);
            tick();
            c++;
            if (last_acc) sent++;
        end
        i_valid = 1'b0;
    endtask

    task automatic drain(input int want, input int budget);
        int c = 0;
        while (got_pay.size() < want && c < budget) begin
            tick();
            c++;
        end
    endtask

    task automatic clear_q();
        got_pay.delete();
        got_tex.delete();
        got_tr.delete();
    endtask

    task automatic test_reset();
        i_nrst  = 1'b1;
        #1 i_nrst = 1'b0;
        i_valid = 1'b1;
        #2;
        n_tests++; if (o_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_ready: got %b want 0", o_ready); end
        n_tests++; if (o_valid !== 1'b0)   begin n_fail++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_tests++; if (o_texReq !== 1'b0)  begin n_fail++; $display("FAIL rst_texReq: got %b want 0", o_texReq); end
        n_tests++; if (o_fillReq !== 1'b0) begin n_fail++; $display("FAIL rst_fillReq: got %b want 0", o_fillReq); end
        n_tests++; if (o_transparent !== 1'b0) begin n_fail++; $display("FAIL rst_transp: got %b want 0", o_transparent); end
        n_tests++; if (o_missCnt !== 16'd0) begin n_fail++; $display("FAIL rst_missCnt: got %0d want 0", o_missCnt); end
        i_valid = 1'b0;
        tick();
        tick();
        i_nrst = 1'b1;
        tick();
        #1;
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_truecolor();
        int s;
        clear_q();
        i_texFormat = 2'd2;
        i_ready     = 1'b1;
        tex_base    = 16'h1000;
        t_acc0 = -1;
        t_val0 = -1;
        feed(8, 48'h100, 19'h0, 40, s);
        drain(8, 40);
        n_tests++; if (t_val0 - t_acc0 != 3) begin n_fail++; $display("FAIL tc_latency: got %0d want 3", t_val0 - t_acc0); end
        n_tests++; if (got_pay.size() != 8) begin n_fail++; $display("FAIL tc_count: got %0d want 8", got_pay.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < got_pay.size()) begin
                n_tests++;
                if (got_tex[i] !== 16'h1000 + 16'(i) || got_pay[i] !== 48'h100 + 48'(i) || got_tr[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tc_pix%0d: got tex %h pay %h tr %b want tex %h pay %h tr 0",
                             i, got_tex[i], got_pay[i], got_tr[i], 16'h1000 + 16'(i), 48'h100 + 48'(i));
                end
            end
        end
    endtask

    task automatic test_clut();
        int s;
        clear_q();
        i_texFormat = 2'd0;
        i_uLSB      = 2'd2;
        tex_base    = 16'hABCD;
        clut_tab[8'h0B] = 16'h0000;
        feed(1, 48'hC0, 19'h0, 10, s);
        drain(1, 20);
        n_tests++; if (idx_s1 !== 8'h0B) begin n_fail++; $display("FAIL clut4_index: got %h want 0b", idx_s1); end
        n_tests++; if (got_tex.size() != 1 || got_tex[0] !== 16'h0000 || got_tr[0] !== 1'b1) begin
            n_fail++; $display("FAIL clut4_texel: got %0d entries, want texel 0000 transparent 1", got_tex.size());
        end
        clear_q();
        i_texDisable = 1'b1;
        feed(1, 48'hC1, 19'h0, 10, s);
        drain(1, 20);
        n_tests++; if (got_tex.size() != 1 || got_tex[0] !== 16'h7FFF || got_tr[0] !== 1'b0) begin
            n_fail++; $display("FAIL untex_texel: got %0d entries, want texel 7fff transparent 0", got_tex.size());
        end
        i_texDisable = 1'b0;
        clear_q();
        i_texFormat = 2'd1;
        i_uLSB      = 2'd1;
        clut_tab[8'hAB] = 16'h1234;
        feed(1, 48'hC2, 19'h0, 10, s);
        drain(1, 20);
        n_tests++; if (idx_s1 !== 8'hAB) begin n_fail++; $display("FAIL clut8_index: got %h want ab", idx_s1); end
        n_tests++; if (got_tex.size() != 1 || got_tex[0] !== 16'h1234 || got_tr[0] !== 1'b0) begin
            n_fail++; $display("FAIL clut8_texel: got %0d entries, want texel 1234 transparent 0", got_tex.size());
        end
        i_uLSB = 2'd0;
    endtask

    task automatic test_miss();
        int s;
        clear_q();
        i_texFormat = 2'd2;
        tex_base    = 16'h2000;
        miss_armed  = 1'b1;
        miss_adr    = 19'h42;
        fill_cyc    = 0;
        fill_hi     = 0;
        feed(5, 48'h200, 19'h40, 100, s);
        drain(5, 60);
        n_tests++; if (fill_hi != 11) begin n_fail++; $display("FAIL miss_fillcycles: got %0d want 11", fill_hi); end
        n_tests++; if (fill_adr_seen !== 17'h10) begin n_fail++; $display("FAIL miss_fillAdr: got %h want 10", fill_adr_seen); end
        n_tests++; if (o_missCnt !== 16'd1) begin n_fail++; $display("FAIL miss_cnt: got %0d want 1", o_missCnt); end
        n_tests++; if (got_pay.size() != 5) begin n_fail++; $display("FAIL miss_count: got %0d want 5", got_pay.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got_pay.size()) begin
                n_tests++;
                if (got_pay[i] !== 48'h200 + 48'(i) || got_tex[i] !== 16'h2040 + 16'(i)) begin
                    n_fail++;
                    $display("FAIL miss_pix%0d: got pay %h tex %h want pay %h tex %h",
                             i, got_pay[i], got_tex[i], 48'h200 + 48'(i), 16'h2040 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        clear_q();
        i_ready  = 1'b0;
        tex_base = 16'h3000;
        for (int c = 0; c < 20; c++) begin
            i_valid   = 1'b1;
            i_payload = 48'h300 + 48'(sent);
            i_texAdr  = 19'(sent);
            tick();
            if (last_acc) sent++;
        end
        n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", o_ready); end
        i_valid = 1'b0;
        tick();
        #1;
        n_tests++; if (sent != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d want 4", sent); end
        n_tests++; if (o_valid !== 1'b1 || o_payload !== 48'h300) begin
            n_fail++; $display("FAIL bp_head: got valid %b pay %h want valid 1 pay 300", o_valid, o_payload);
        end
        i_ready = 1'b1;
        drain(4, 20);
        tick();
        tick();
        n_tests++; if (got_pay.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got_pay.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got_pay.size()) begin
                n_tests++;
                if (got_pay[i] !== 48'h300 + 48'(i) || got_tex[i] !== 16'h3000 + 16'(i)) begin
                    n_fail++;
                    $display("FAIL bp_pix%0d: got pay %h tex %h want pay %h tex %h",
                             i, got_pay[i], got_tex[i], 48'h300 + 48'(i), 16'h3000 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_flush_fill();
        int s;
        int c = 0;
        clear_q();
        i_texFormat = 2'd2;
        miss_armed  = 1'b1;
        miss_adr    = 19'h80;
        fill_cyc    = 0;
        fill_hi     = 0;
        feed(1, 48'h400, 19'h80, 10, s);
        while (!o_fillReq && c < 10) begin
            tick();
            c++;
        end
        tick();
        tick();
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        #1;
        n_tests++; if (fill_hi != 11) begin n_fail++; $display("FAIL fl_fillcycles: got %0d want 11", fill_hi); end
        n_tests++; if (o_fillReq !== 1'b0) begin n_fail++; $display("FAIL fl_fillReq: got %b want 0", o_fillReq); end
        n_tests++; if (got_pay.size() != 0) begin n_fail++; $display("FAIL fl_output: got %0d pixels want 0", got_pay.size()); end
        n_tests++; if (o_inFlight !== 1'b0) begin n_fail++; $display("FAIL fl_inFlight: got %b want 0", o_inFlight); end
        n_tests++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL fl_ready: got %b want 1", o_ready); end
        n_tests++; if (o_missCnt !== 16'd2) begin n_fail++; $display("FAIL fl_missCnt: got %0d want 2", o_missCnt); end
    endtask

    task automatic test_async_reset();
        int s;
        clear_q();
        i_ready  = 1'b0;
        tex_base = 16'h5000;
        feed(3, 48'h500, 19'h0, 20, s);
        for (int k = 0; k < 5; k++) tick();
        #1;
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ar_prefill: got valid %b want 1", o_valid); end
        #2 i_nrst = 1'b0;
        #1;
        n_tests++; if (o_valid !== 1'b0)    begin n_fail++; $display("FAIL ar_valid: got %b want 0", o_valid); end
        n_tests++; if (o_missCnt !== 16'd0) begin n_fail++; $display("FAIL ar_missCnt: got %0d want 0", o_missCnt); end
        n_tests++; if (o_inFlight !== 1'b0) begin n_fail++; $display("FAIL ar_inFlight: got %b want 0", o_inFlight); end
        n_tests++; if (o_ready !== 1'b0)    begin n_fail++; $display("FAIL ar_ready: got %b want 0", o_ready); end
        i_nrst  = 1'b1;
        i_ready = 1'b1;
        tick();
        tick();
        #1;
        n_tests++; if (o_valid !== 1'b0 || got_pay.size() != 0) begin
            n_fail++; $display("FAIL ar_after: got valid %b popped %0d want 0 0", o_valid, got_pay.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) clut_tab[i] = 16'h4000 + 16'(i);
        i_texFormat  = 2'd2;
        i_texDisable = 1'b0;
        i_flush      = 1'b0;
        i_valid      = 1'b0;
        i_payload    = '0;
        i_texAdr     = '0;
        i_uLSB       = 2'd0;
        i_texHit     = 1'b0;
        i_texMiss    = 1'b0;
        i_texData    = '0;
        i_fillDone   = 1'b0;
        i_clutData   = '0;
        i_ready      = 1'b1;
        last_acc     = 1'b0;
        acc_prev     = 1'b0;
        idx_s1       = '0;
        miss_armed   = 1'b0;
        miss_adr     = '0;
        tex_base     = '0;
        fill_delay   = 10;
        fill_cyc     = 0;
        fill_hi      = 0;
        fill_adr_seen = '0;
        t_acc0       = -1;
        t_val0       = -1;
        test_reset();
        test_truecolor();
        test_clut();
        test_miss();
        test_back_to_back();
        test_flush_fill();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_pipe_ctrl_n.md
Name: gpu_pipe_ctrl_n

Overview:
Parametrised successor of the 3-stage texel/CLUT pixel pipeline controller, sitting between the rasteriser pixel generator and the pixel write-back buffer.
- Issues texture-cache lookups and resolves misses with its own fill/replay FSM; the upstream no longer has to drive a global pause.
- Converts texture data into CLUT indices and selects the final texel.
- Delivers pixels through a valid/ready output FIFO whose depth is a parameter, so write-back backpressure never stalls in-flight cache accesses.

Parameters:
PAYLOAD_W, 48, opaque per-pixel payload carried alongside the texel (scrX, scrY, RGB, BGMSK, state spike).
TEXADR_W, 19, half-word texel address width; the fill address is TEXADR_W-2 bits (8-byte line).
FIFO_DEPTH, 4, output FIFO entries; power of two, >=4.
CNT_W, 16, width of the saturating miss counter.

Ports:
clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_texFormat  in  2  0=4bpp, 1=8bpp, 2/3=true colour; static per primitive
i_texDisable  in  1  untextured primitive
i_flush  in  1  synchronous pipeline clear
i_valid  in  1  input pixel valid
o_ready  out  1  pipeline accepts the input pixel this cycle
i_payload  in  PAYLOAD_W  pixel payload
i_texAdr  in  TEXADR_W  texel address
i_uLSB  in  2  U coordinate LSBs
o_texReq  out  1  texture cache lookup request
o_texAdr  out  TEXADR_W  lookup address
i_texHit  in  1  hit, one cycle after the request
i_texMiss  in  1  miss, one cycle after the request
i_texData  in  16  data, one cycle after the request
o_fillReq  out  1  cache line fill request, level signal
o_fillAdr  out  TEXADR_W-2  line address to fill
i_fillDone  in  1  fill-complete pulse
o_clutIndex  out  8  palette index; data returns on i_clutData one cycle later
i_clutData  in  16  palette colour
o_valid  out  1  output FIFO head valid
i_ready  in  1  write-back accepts the head
o_payload  out  PAYLOAD_W  head payload
o_texel  out  16  head texel
o_transparent  out  1  head texel is transparent
o_inFlight  out  1  any of S1, S2 or the FIFO is occupied
o_missCnt  out  CNT_W  saturating count of texture misses

Behaviour:
- Reset (i_nrst=0, asynchronous):
  - all stage valids cleared, FIFO emptied, FSM=RUN, o_missCnt=0.
  - o_valid, o_texReq, o_fillReq and o_transparent are 0; o_ready=0 while reset is asserted, 1 from the first cycle after release.
- Stages:
  - S0 accepts a pixel when i_valid & o_ready. o_texReq = i_valid & o_ready & !i_texDisable; o_texAdr = i_texAdr.
  - S1 registers payload, uLSB and a textured flag. In S1, index: fmt0 = nibble i_uLSB of i_texData; fmt1 = byte i_uLSB[0]; fmt2/3 = don't care. o_clutIndex is driven combinationally from this.
  - S2 registers S1 plus i_texData.
  - Texel: untextured = 16'h7FFF; true colour = registered tex data; palettised = i_clutData.
  - S2 pushes into the FIFO. Pixel latency with no miss and an empty FIFO: o_valid 3 cycles after acceptance.
- Credit:
  - o_ready = (FSM==RUN) & !i_flush & (FIFO free entries > count of valid S1+S2).
  - S1 and S2 never stall on FIFO full.
- Miss FSM:
  - RUN: valid textured S1 with i_texMiss -> FILL. The S1 pixel is held (S2 receives a bubble), o_fillAdr = S1 address[TEXADR_W-1:2], o_missCnt increments and saturates at its maximum.
  - FILL: o_fillReq=1 until i_fillDone; on i_fillDone -> REPLAY.
  - REPLAY: o_texReq=1 with the held S1 address, one cycle -> CHECK.
  - CHECK: i_texHit -> S1 advances to S2 -> RUN. A repeated i_texMiss -> FILL; this counts again.
  - i_texHit and i_texMiss both 1 in the same cycle: treated as a miss.
- Transparent: texel[14:0]==0 & textured pixel. Always 0 when i_texDisable.
- FIFO:
  - Push and pop in the same cycle when full: legal, count unchanged.
  - Pop when empty: ignored.
  - o_payload and o_texel are stable while o_valid & !i_ready.
- Flush: i_flush clears S1, S2 and the FIFO in the next cycle.
  - In FILL, the FSM stays in FILL until i_fillDone, then goes directly to RUN. The held pixel is discarded; there is no replay.
  - A flush in REPLAY or CHECK -> RUN.
- i_texFormat and i_texDisable change only when o_inFlight=0. Changing them while o_inFlight=1 is unsupported.

Test Plan:
- Reset, then 8 true-colour hits, i_texData = 16'h1000+n, i_ready=1 -> 8 outputs in order; first o_valid 3 cycles after the first accept; texels 16'h1000..1007.
- fmt0, i_texData=16'hABCD, i_uLSB=2 -> o_clutIndex=8'h0B. i_clutData=16'h0000 -> o_texel=0, o_transparent=1. Same stimulus with i_texDisable=1 -> o_texel=16'h7FFF, o_transparent=0.
- Miss on the 3rd of 5 pixels, i_fillDone 10 cycles later -> o_fillReq high until i_fillDone; o_fillAdr = adr>>2; replay hit; output order preserved; o_missCnt=1.
- i_ready=0 for 20 cycles with i_valid held -> exactly FIFO_DEPTH pixels accepted, o_ready=0, no loss or duplication after i_ready=1.
- i_flush during FILL -> o_fillReq stays high until i_fillDone, FSM returns to RUN, held pixel never output, o_inFlight=0 afterwards.
- i_nrst asserted while the FIFO holds 3 pixels -> o_valid=0 immediately (asynchronous), o_missCnt=0.
